// File: rtl/resize_seq_pkg.sv
// Shared definitions for the resize sequencer and its bench.
//   state_t           : sequencer phases
//   SCALE_UP/DOWN     : encoding of the latched scale direction
//   calc_n_in/...     : per-frame pixel counts derived from image geometry
package resize_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic SCALE_UP   = 1'b1;
    localparam logic SCALE_DOWN = 1'b0;

    // Pixels streamed into the filter per frame.
    function automatic int calc_n_in(input int w, input int h);
        return w * h;
    endfunction

    // Pixels produced when enlarging by fs in both dimensions.
    function automatic int calc_n_out_up(input int w, input int h, input int fs);
        return (w * fs) * (h * fs);
    endfunction

    // Pixels produced when shrinking; the +1/+2 bias matches the filter's
    // edge handling, so the division truncates the way the filter does.
    function automatic int calc_n_out_down(input int w, input int h, input int fs);
        return ((w + 1) / fs) * ((h + 2) / fs);
    endfunction

endpackage

// File: rtl/resize_seq_if.sv
// Pixel stream bundle between the source/sink and the resize sequencer.
//   in_valid/in_ready/in_pixel    : input stream, valid/ready handshake
//   out_valid/out_pixel/out_last  : output stream, no backpressure
// master = source/sink side, slave = sequencer side.
interface resize_seq_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic [PIX_W-1:0] out_pixel;
    logic             out_last;

    modport master (
        output in_valid,
        output in_pixel,
        input  in_ready,
        input  out_valid,
        input  out_pixel,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_pixel,
        output in_ready,
        output out_valid,
        output out_pixel,
        output out_last
    );
endinterface

// File: rtl/resize_seq_frame_cnt.sv
// Frame pixel counter with clear, count enable and terminal-count compare.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (start of frame)
//   inc      : count one pixel
//   term     : value at which hit asserts
//   hit      : current count equals term
module resize_seq_frame_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         hit
);

    logic [W-1:0] cnt_r;

    // Pixel count register; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign hit = (cnt_r == term);

endmodule

// File: rtl/resize_seq.sv
// Sequencer for resize_filter: loads one frame of WIDTH*HEIGHT pixels into
// the filter, then streams the resized frame out with valid/last, and pulses
// done once the final pixel has left.
//   clk, rst          : clock, asynchronous active-high reset
//   start, scale_sel  : begin a frame (IDLE only), direction latched with it
//   px                : input/output pixel streams (slave side)
//   filt_enable       : load strobe to the filter, same cycle as a transfer
//   filt_enable_proc  : process enable to the filter (SETTLE and STREAM)
//   filt_scale        : latched scale direction
//   filt_pixel_in     : pixel forwarded to the filter
//   filt_pixel_out    : pixel returned by the filter
//   busy, done        : not-IDLE flag, end-of-frame pulse
module resize_seq
    import resize_seq_pkg::*;
#(
    parameter int WIDTH       = 410,
    parameter int HEIGHT      = 361,
    parameter int FILTER_SIZE = 3,
    parameter int PIX_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             scale_sel,
    resize_seq_if.slave      px,
    output logic             filt_enable,
    output logic             filt_enable_proc,
    output logic             filt_scale,
    output logic [PIX_W-1:0] filt_pixel_in,
    input  logic [PIX_W-1:0] filt_pixel_out,
    output logic             busy,
    output logic             done
);

    localparam int N_IN       = calc_n_in(WIDTH, HEIGHT);
    localparam int N_OUT_UP   = calc_n_out_up(WIDTH, HEIGHT, FILTER_SIZE);
    localparam int N_OUT_DOWN = calc_n_out_down(WIDTH, HEIGHT, FILTER_SIZE);
    localparam int N_OUT_MAX  = (N_OUT_UP > N_OUT_DOWN) ? N_OUT_UP : N_OUT_DOWN;
    localparam int IN_W       = $clog2(N_IN + 1);
    localparam int OUT_W      = $clog2(N_OUT_MAX + 1);

    localparam logic [IN_W-1:0]  IN_TERM       = IN_W'(N_IN - 1);
    localparam logic [OUT_W-1:0] OUT_TERM_UP   = OUT_W'(N_OUT_UP - 1);
    localparam logic [OUT_W-1:0] OUT_TERM_DOWN = OUT_W'(N_OUT_DOWN - 1);

    state_t           state_r;
    logic             in_ready_r;
    logic             proc_r;
    logic             scale_r;
    logic             out_valid_r;
    logic [PIX_W-1:0] out_pixel_r;
    logic             out_last_r;
    logic             busy_r;
    logic             done_r;

    logic             xfer_s;
    logic             clr_s;
    logic             out_inc_s;
    logic             in_hit_s;
    logic             out_hit_s;
    logic [OUT_W-1:0] out_term_s;

    // in_ready_r is only ever high in LOAD, so it doubles as the state qualifier.
    assign xfer_s    = in_ready_r & px.in_valid;
    assign clr_s     = (state_r == IDLE) & start;
    // The output counter advances whenever a pixel is captured into the
    // output register: once leaving SETTLE, then every STREAM cycle except
    // the one already presenting the last pixel. Its count is therefore the
    // index of the pixel being captured, which makes out_last a plain compare.
    assign out_inc_s = (state_r == SETTLE) | ((state_r == STREAM) & ~out_last_r);
    assign out_term_s = (scale_r == SCALE_UP) ? OUT_TERM_UP : OUT_TERM_DOWN;

    resize_seq_frame_cnt #(.W(IN_W)) u_in_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .inc  (xfer_s),
        .term (IN_TERM),
        .hit  (in_hit_s)
    );

    resize_seq_frame_cnt #(.W(OUT_W)) u_out_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .inc  (out_inc_s),
        .term (out_term_s),
        .hit  (out_hit_s)
    );

    // Phase sequencing and all registered stream/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            proc_r      <= 1'b0;
            scale_r     <= SCALE_DOWN;
            out_valid_r <= 1'b0;
            out_pixel_r <= {PIX_W{1'b0}};
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        scale_r    <= scale_sel;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    if (xfer_s && in_hit_s) begin
                        in_ready_r <= 1'b0;
                        proc_r     <= 1'b1;
                        state_r    <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Filter output is valid during SETTLE; capture the first pixel.
                    out_valid_r <= 1'b1;
                    out_pixel_r <= filt_pixel_out;
                    out_last_r  <= out_hit_s;
                    state_r     <= STREAM;
                end
                STREAM: begin
                    if (out_last_r) begin
                        out_valid_r <= 1'b0;
                        out_pixel_r <= {PIX_W{1'b0}};
                        out_last_r  <= 1'b0;
                        proc_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        out_pixel_r <= filt_pixel_out;
                        out_last_r  <= out_hit_s;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    proc_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_pixel_r <= {PIX_W{1'b0}};
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    // Load path is a same-cycle pass-through; the pixel is zeroed when no
    // transfer happens so the filter input is quiet outside transfers.
    assign filt_enable      = xfer_s;
    assign filt_pixel_in    = xfer_s ? px.in_pixel : {PIX_W{1'b0}};
    assign filt_enable_proc = proc_r;
    assign filt_scale       = scale_r;
    assign px.in_ready      = in_ready_r;
    assign px.out_valid     = out_valid_r;
    assign px.out_pixel     = out_pixel_r;
    assign px.out_last      = out_last_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule
